sys_ctrl_mc: RTL and testbench

// Multi-channel system control register block on the SMI IOC bus (5-bit IOC, 8-bit data, cs/fetch/load strobes).

---
 rtl/sys_ctrl_mc.sv | 173 +++++++++++++++++
 tb/tb_sys_ctrl_mc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_mc.sv
// System control register block on the SMI IOC bus: version/ID constants, debug mode,
// per-channel TX gap and sync-type config, self-timed soft-sync pulses and a sticky error register.
module sys_ctrl_mc #(
  parameter int         N_CH       = 2,
  parameter int         GAP_W      = 4,
  parameter int         SYNC_LEN   = 4,
  parameter logic [7:0] MODULE_VER = 8'h02,
  parameter logic [7:0] SYSTEM_VER = 8'h01,
  parameter logic [7:0] MANU_ID    = 8'h01
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_b,
  input  logic [4:0]            i_ioc,
  input  logic [7:0]            i_data_in,
  output logic [7:0]            o_data_out,
  input  logic                  i_cs,
  input  logic                  i_fetch_cmd,
  input  logic                  i_load_cmd,
  input  logic [7:0]            i_err_event,
  output logic                  o_err_irq,
  output logic                  o_debug_loopback,
  output logic [N_CH*GAP_W-1:0] o_tx_sample_gap,
  output logic [N_CH-1:0]       o_rx_sync_type,
  output logic [N_CH-1:0]       o_tx_sync_type,
  output logic [N_CH-1:0]       o_rx_sync,
  output logic [N_CH-1:0]       o_tx_sync
);

  localparam logic [4:0] IOC_MODULE_VER = 5'd0;
  localparam logic [4:0] IOC_SYSTEM_VER = 5'd1;
  localparam logic [4:0] IOC_MANU_ID    = 5'd2;
  localparam logic [4:0] IOC_ERR_STATE  = 5'd3;
  localparam logic [4:0] IOC_ERR_CLEAR  = 5'd4;
  localparam logic [4:0] IOC_DEBUG      = 5'd5;
  localparam logic [4:0] IOC_CH_SEL     = 5'd6;
  localparam logic [4:0] IOC_CH_CFG     = 5'd7;
  localparam logic [4:0] IOC_SOFT_SYNC  = 5'd8;
  localparam logic [4:0] IOC_SYNC_LEN   = 5'd9;
  localparam logic [4:0] IOC_ERR_MASK   = 5'd10;

  // A programmed length of zero still produces a one-cycle pulse.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

  logic                       fetch, load;
  logic [7:0]                 data_out_q, data_out_d;
  logic [7:0]                 err_state_q, err_state_d, err_clr;
  logic                       err_irq_q, err_irq_d;
  logic [7:0]                 err_mask_q, err_mask_d;
  logic                       loopback_q, loopback_d;
  logic [1:0]                 ch_sel_q, ch_sel_d;
  logic [N_CH-1:0][GAP_W-1:0] gap_q, gap_d;
  logic [N_CH-1:0]            rx_type_q, rx_type_d, tx_type_q, tx_type_d;
  logic [7:0]                 sync_len_q, sync_len_d;
  logic [N_CH-1:0][7:0]       rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [7:0]                 cfg_rd;

  // Fetch has priority: a simultaneous load is dropped.
  always_comb begin
    fetch = i_cs & i_fetch_cmd;
    load  = i_cs & i_load_cmd & ~i_fetch_cmd;
  end

  always_comb begin
    cfg_rd = 8'h00;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel_q == 2'(c)) cfg_rd = {2'b00, tx_type_q[c], rx_type_q[c], 4'(gap_q[c])};
    end
    data_out_d = data_out_q;
    if (fetch) begin
      case (i_ioc)
        IOC_MODULE_VER: data_out_d = MODULE_VER;
        IOC_SYSTEM_VER: data_out_d = SYSTEM_VER;
        IOC_MANU_ID:    data_out_d = MANU_ID;
        IOC_ERR_STATE:  data_out_d = err_state_q;
        IOC_CH_SEL:     data_out_d = {6'b0, ch_sel_q};
        IOC_CH_CFG:     data_out_d = cfg_rd;
        IOC_SYNC_LEN:   data_out_d = sync_len_q;
        IOC_ERR_MASK:   data_out_d = err_mask_q;
        default:        data_out_d = 8'h00;
      endcase
    end
  end

  // Only debug bit 3 has any effect, so it is the only one kept.
  always_comb begin
    err_clr    = 8'h00;
    loopback_d = loopback_q;
    ch_sel_d   = ch_sel_q;
    gap_d      = gap_q;
    rx_type_d  = rx_type_q;
    tx_type_d  = tx_type_q;
    sync_len_d = sync_len_q;
    err_mask_d = err_mask_q;
    if (load) begin
      case (i_ioc)
        IOC_ERR_CLEAR: err_clr    = i_data_in;
        IOC_DEBUG:     loopback_d = i_data_in[3];
        IOC_CH_SEL:    ch_sel_d   = i_data_in[1:0];
        IOC_CH_CFG: begin
          for (int c = 0; c < N_CH; c++) begin
            if (ch_sel_q == 2'(c)) begin
              gap_d[c]     = i_data_in[GAP_W-1:0];
              rx_type_d[c] = i_data_in[4];
              tx_type_d[c] = i_data_in[5];
            end
          end
        end
        IOC_SYNC_LEN:  sync_len_d = i_data_in;
        IOC_ERR_MASK:  err_mask_d = i_data_in;
        default: ;
      endcase
    end
    // New events are ORed in after the clear so a simultaneous set survives.
    err_state_d = (err_state_q & ~err_clr) | (i_err_event & err_mask_q);
    err_irq_d   = |err_state_q;
  end

  // A trigger reloads the counter even mid-pulse, stretching the pulse without a gap.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      rx_cnt_d[c] = (rx_cnt_q[c] != 8'd0) ? rx_cnt_q[c] - 8'd1 : 8'd0;
      tx_cnt_d[c] = (tx_cnt_q[c] != 8'd0) ? tx_cnt_q[c] - 8'd1 : 8'd0;
      if (load && (i_ioc == IOC_SOFT_SYNC)) begin
        if (i_data_in[c])     rx_cnt_d[c] = eff_len(sync_len_q);
        if (i_data_in[4 + c]) tx_cnt_d[c] = eff_len(sync_len_q);
      end
      o_rx_sync[c] = |rx_cnt_q[c];
      o_tx_sync[c] = |tx_cnt_q[c];
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      data_out_q  <= 8'h00;
      err_state_q <= 8'h00;
      err_irq_q   <= 1'b0;
      err_mask_q  <= 8'hFF;
      loopback_q  <= 1'b0;
      ch_sel_q    <= 2'b00;
      gap_q       <= '0;
      rx_type_q   <= '0;
      tx_type_q   <= '0;
      sync_len_q  <= 8'(SYNC_LEN);
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
    end else begin
      data_out_q  <= data_out_d;
      err_state_q <= err_state_d;
      err_irq_q   <= err_irq_d;
      err_mask_q  <= err_mask_d;
      loopback_q  <= loopback_d;
      ch_sel_q    <= ch_sel_d;
      gap_q       <= gap_d;
      rx_type_q   <= rx_type_d;
      tx_type_q   <= tx_type_d;
      sync_len_q  <= sync_len_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  always_comb begin
    o_data_out       = data_out_q;
    o_err_irq        = err_irq_q;
    o_debug_loopback = loopback_q;
    o_tx_sample_gap  = gap_q;
    o_rx_sync_type   = rx_type_q;
    o_tx_sync_type   = tx_type_q;
  end

endmodule

// File: tb/tb_sys_ctrl_mc.sv
// Self-checking bench for sys_ctrl_mc: expected values are queued as stimulus is driven
// and popped when the DUT output becomes valid.
module tb_sys_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [4:0] ioc;
  logic [7:0] din;
  logic [7:0] dout;
  logic       cs, fetch, load;
  logic [7:0] ev;
  logic       irq, loopback;
  logic [7:0] gap;
  logic [1:0] rx_type, tx_type, rx_sync, tx_sync;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  sys_ctrl_mc dut (
    .i_sys_clk        (clk),
    .i_rst_b          (rst_b),
    .i_ioc            (ioc),
    .i_data_in        (din),
    .o_data_out       (dout),
    .i_cs             (cs),
    .i_fetch_cmd      (fetch),
    .i_load_cmd       (load),
    .i_err_event      (ev),
    .o_err_irq        (irq),
    .o_debug_loopback (loopback),
    .o_tx_sample_gap  (gap),
    .o_rx_sync_type   (rx_type),
    .o_tx_sync_type   (tx_type),
    .o_rx_sync        (rx_sync),
    .o_tx_sync        (tx_sync)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [15:0] v);
    sb.push_back('{nm, v});
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cs = 1'b1; load = 1'b1; ioc = a; din = d;
    tick();
    cs = 1'b0; load = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] x, input string nm);
    push(nm, 16'(x));
    cs = 1'b1; fetch = 1'b1; ioc = a;
    tick();
    cs = 1'b0; fetch = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] a_t [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31, 5'd9, 5'd10};
    logic [7:0] x_t [7] = '{8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04, 8'hFF};
    rst_b = 1'b1; ioc = '0; din = '0; cs = 0; fetch = 0; load = 0; ev = '0;
    #2 rst_b = 1'b0;
    #3;
    checks++;
    if ({dout, irq, loopback, gap, rx_type, tx_type, rx_sync, tx_sync} !== 22'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0",
               {dout, irq, loopback, gap, rx_type, tx_type, rx_sync, tx_sync});
    end
    @(negedge clk) rst_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd(a_t[i], x_t[i], $sformatf("rd_ioc%0d", a_t[i]));
      e = sb.pop_front();
      checks++;
      if (dout !== e.v[7:0]) begin
        errs++;
        $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]);
      end
    end
    // Fetch without cs must leave the last read value (err_mask, FF) in place.
    push("cs_low_fetch", 16'h00FF);
    cs = 1'b0; fetch = 1'b1; ioc = 5'd0;
    tick();
    fetch = 1'b0;
    e = sb.pop_front();
    checks++;
    if (dout !== e.v[7:0]) begin
      errs++;
      $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]);
    end
  endtask

  task automatic test_ch_cfg();
    wr(5'd6, 8'h01);
    wr(5'd7, 8'h25);
    checks++;
    if ({gap, rx_type, tx_type} !== {8'h50, 2'b00, 2'b10}) begin
      errs++;
      $display("FAIL cfg_ch1: got %h want %h", {gap, rx_type, tx_type}, {8'h50, 2'b00, 2'b10});
    end
    rd(5'd7, 8'h25, "rd_cfg_ch1");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    wr(5'd6, 8'h00);
    rd(5'd7, 8'h00, "rd_cfg_ch0_empty");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    wr(5'd7, 8'h13);
    checks++;
    if ({gap, rx_type, tx_type} !== {8'h53, 2'b01, 2'b10}) begin
      errs++;
      $display("FAIL cfg_ch0: got %h want %h", {gap, rx_type, tx_type}, {8'h53, 2'b01, 2'b10});
    end
    wr(5'd6, 8'h03);
    wr(5'd7, 8'h3F);
    checks++;
    if ({gap, rx_type, tx_type} !== {8'h53, 2'b01, 2'b10}) begin
      errs++;
      $display("FAIL cfg_bad_ch_write: got %h want %h", {gap, rx_type, tx_type}, {8'h53, 2'b01, 2'b10});
    end
    rd(5'd7, 8'h00, "rd_cfg_bad_ch");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    rd(5'd6, 8'h03, "rd_ch_sel");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    // Simultaneous fetch and load: read happens, write is dropped.
    wr(5'd6, 8'h00);
    push("fetch_wins_read", 16'h0013);
    cs = 1'b1; fetch = 1'b1; load = 1'b1; ioc = 5'd7; din = 8'hFF;
    tick();
    cs = 1'b0; fetch = 1'b0; load = 1'b0;
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    checks++;
    if ({gap, rx_type, tx_type} !== {8'h53, 2'b01, 2'b10}) begin
      errs++;
      $display("FAIL fetch_wins_cfg: got %h want %h", {gap, rx_type, tx_type}, {8'h53, 2'b01, 2'b10});
    end
  endtask

  task automatic test_sync_pulse();
    wr(5'd9, 8'd3);
    for (int k = 0; k < 4; k++) push($sformatf("pulse3_c%0d", k), (k < 3) ? 16'h0006 : 16'h0000);
    wr(5'd8, 8'h21);
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front(); checks++;
      if ({rx_sync, tx_sync} !== e.v[3:0]) begin
        errs++; $display("FAIL %s: got %b want %b", e.nm, {rx_sync, tx_sync}, e.v[3:0]);
      end
      tick();
    end
    wr(5'd9, 8'd0);
    push("pulse0_c0", 16'h000C);
    push("pulse0_c1", 16'h0000);
    wr(5'd8, 8'h03);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front(); checks++;
      if ({rx_sync, tx_sync} !== e.v[3:0]) begin
        errs++; $display("FAIL %s: got %b want %b", e.nm, {rx_sync, tx_sync}, e.v[3:0]);
      end
      tick();
    end
    wr(5'd9, 8'd2);
    push("mask_hi_c0", 16'h0000);
    push("mask_hi_c1", 16'h0000);
    wr(5'd8, 8'hCC);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front(); checks++;
      if ({rx_sync, tx_sync} !== e.v[3:0]) begin
        errs++; $display("FAIL %s: got %b want %b", e.nm, {rx_sync, tx_sync}, e.v[3:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd9, 8'd3);
    for (int k = 0; k < 6; k++) push($sformatf("retrig_c%0d", k), (k < 5) ? 16'h0004 : 16'h0000);
    wr(5'd8, 8'h01);
    for (int k = 0; k < 6; k++) begin
      e = sb.pop_front(); checks++;
      if ({rx_sync, tx_sync} !== e.v[3:0]) begin
        errs++; $display("FAIL %s: got %b want %b", e.nm, {rx_sync, tx_sync}, e.v[3:0]);
      end
      if (k == 1) wr(5'd8, 8'h01);
      else tick();
    end
  endtask

  task automatic test_errors();
    wr(5'd10, 8'h0F);
    ev = 8'hF3;
    tick();
    ev = 8'h00;
    checks++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_delay: got %b want 0", irq); end
    rd(5'd3, 8'h03, "err_masked_set");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    checks++;
    if (irq !== 1'b1) begin errs++; $display("FAIL irq_set: got %b want 1", irq); end
    ev = 8'h01;
    wr(5'd4, 8'h01);
    ev = 8'h00;
    rd(5'd3, 8'h03, "err_set_wins");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    wr(5'd4, 8'h03);
    checks++;
    if (irq !== 1'b1) begin errs++; $display("FAIL irq_hold: got %b want 1", irq); end
    rd(5'd3, 8'h00, "err_cleared");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    checks++;
    if (irq !== 1'b0) begin errs++; $display("FAIL irq_drop: got %b want 0", irq); end
    ev = 8'h01;
    tick();
    ev = 8'h00;
    wr(5'd10, 8'h00);
    rd(5'd3, 8'h01, "err_mask_keeps");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    wr(5'd4, 8'hFF);
    wr(5'd10, 8'hFF);
  endtask

  task automatic test_reset_mid();
    wr(5'd5, 8'h08);
    checks++;
    if (loopback !== 1'b1) begin errs++; $display("FAIL loopback_set: got %b want 1", loopback); end
    wr(5'd9, 8'd5);
    wr(5'd6, 8'h01);
    wr(5'd7, 8'hFF);
    wr(5'd8, 8'h33);
    tick();
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({dout, irq, loopback, gap, rx_type, tx_type, rx_sync, tx_sync} !== 22'd0) begin
      errs++;
      $display("FAIL async_reset_outputs: got %h want 0",
               {dout, irq, loopback, gap, rx_type, tx_type, rx_sync, tx_sync});
    end
    @(negedge clk) rst_b = 1'b1;
    rd(5'd9, 8'h04, "reset_sync_len");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    rd(5'd6, 8'h00, "reset_ch_sel");
    e = sb.pop_front(); checks++;
    if (dout !== e.v[7:0]) begin errs++; $display("FAIL %s: got %h want %h", e.nm, dout, e.v[7:0]); end
    checks++;
    if ({rx_sync, tx_sync, loopback} !== 5'd0) begin
      errs++; $display("FAIL no_pulse_resume: got %b want 0", {rx_sync, tx_sync, loopback});
    end
  endtask

  initial begin
    test_reset();
    test_ch_cfg();
    test_sync_pulse();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
